// File: rtl/rom_arb_pkg.sv
// Shared types and limits for the image-ROM port arbiter.
package rom_arb_pkg;

  localparam int NUM_REQ_MAX     = 8;
  localparam int ROM_LATENCY_MAX = 3;

  typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_id_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping to 0.
module rr_picker
  import rom_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  req_id_t      ptr,
  output logic [N-1:0] gnt,
  output req_id_t      idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;

  always_comb begin
    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    dbl  = {req, req} >> ptr;
    rot  = dbl[N-1:0];
    pick = rot & (~rot + N'(1));
    back = {pick, pick} << ptr;
    gnt  = back[2*N-1:N];
    idx  = '0;
    for (int k = 0; k < N; k++) begin
      if (((gnt >> k) & N'(1)) != '0) idx = idx | req_id_t'(k);
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one registered-read image ROM between pixel requesters.
// Define ROM_ARB_LOCK_EN to build the burst-lock FSM; otherwise lock is ignored.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 12,
  parameter int ROM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ-1:0]            lock,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_dout,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int      IW      = $bits(req_id_t);
  localparam req_id_t LAST_ID = req_id_t'(NUM_REQ - 1);

  req_id_t                     ptr_reg, ptr_next, ptr_adv;
  logic [NUM_REQ-1:0]          pick_gnt, gnt_c;
  req_id_t                     pick_idx, gnt_idx;
  logic [ADDR_WIDTH-1:0]       sel_addr, addr_hold_reg;
  logic [ROM_LATENCY-1:0]      tag_v_reg;
  logic [ROM_LATENCY*IW-1:0]   tag_id_reg;
  logic                        tag_v_last;
  req_id_t                     tag_id_last;
  logic [DATA_WIDTH-1:0]       rdata_hold_reg;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req (req),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign ptr_adv = (pick_idx == LAST_ID) ? '0 : req_id_t'(pick_idx + 1'b1);

`ifdef ROM_ARB_LOCK_EN
  lock_state_e         state_reg, state_next;
  logic [NUM_REQ-1:0]  owner_reg, owner_next;
  req_id_t             owner_id_reg, owner_id_next;
  logic                hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      owner_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      owner_id_reg <= owner_id_next;
    end
  end

  always_comb begin
    hold          = (state_reg == LOCKED) && ((owner_reg & req & lock) != '0);
    state_next    = IDLE;
    owner_next    = owner_reg;
    owner_id_next = owner_id_reg;
    gnt_c         = pick_gnt;
    gnt_idx       = pick_idx;
    ptr_next      = ptr_reg;
    if (hold) begin
      gnt_c      = owner_reg;
      gnt_idx    = owner_id_reg;
      state_next = LOCKED;
    end else begin
      // Lock released (or never held): this cycle arbitrates normally.
      if (pick_gnt != '0) ptr_next = ptr_adv;
      if ((pick_gnt & lock) != '0) begin
        state_next    = LOCKED;
        owner_next    = pick_gnt;
        owner_id_next = pick_idx;
      end
    end
  end
`else
  logic lock_unused;
  assign lock_unused = ^lock;

  always_comb begin
    gnt_c    = pick_gnt;
    gnt_idx  = pick_idx;
    ptr_next = (pick_gnt != '0) ? ptr_adv : ptr_reg;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

  assign gnt      = rst_n ? gnt_c : '0;
  assign sel_addr = ADDR_WIDTH'(addr >> (gnt_idx * ADDR_WIDTH));
  assign rom_addr = !rst_n ? '0 : ((gnt != '0) ? sel_addr : addr_hold_reg);

  // Tag pipeline mirrors the ROM read latency so data is routed to its owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_hold_reg <= '0;
      tag_v_reg     <= '0;
      tag_id_reg    <= '0;
    end else begin
      addr_hold_reg <= rom_addr;
      tag_v_reg     <= (tag_v_reg << 1) | ROM_LATENCY'(gnt != '0);
      tag_id_reg    <= (tag_id_reg << IW) | (ROM_LATENCY*IW)'(gnt_idx);
    end
  end

  assign tag_v_last  = tag_v_reg[ROM_LATENCY-1] && rst_n;
  assign tag_id_last = tag_id_reg[ROM_LATENCY*IW-1 -: IW];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
    assign rvalid[gi] = tag_v_last && (tag_id_last == req_id_t'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          rdata_hold_reg <= '0;
    else if (tag_v_last) rdata_hold_reg <= rom_dout;
  end

  assign rdata = !rst_n ? '0 : (tag_v_last ? rom_dout : rdata_hold_reg);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomised bench for rom_port_arbiter against a queue-based reference model.
module tb_rom_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 20;
  localparam int DW  = 12;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_dout, rdata;

  always #5 clk = ~clk;

  rom_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .lock(lock), .gnt(gnt),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .rvalid(rvalid), .rdata(rdata)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    logic [31:0] h;
    h = ({12'd0, a} * 32'd40503) ^ ({12'd0, a} >> 9);
    return h[DW-1:0] ^ h[DW+7:8];
  endfunction

  // Behavioural ROM with LAT cycles of registered read delay.
  logic [LAT*AW-1:0] rom_pipe = '0;
  always @(posedge clk) rom_pipe <= (rom_pipe << AW) | (LAT*AW)'(rom_addr);
  assign rom_dout = rom_f(rom_pipe[LAT*AW-1 -: AW]);

  always @(negedge clk) begin
    #2;
    if (rvalid != '0) $display("read return t=%0t rvalid=%b rdata=%h", $time, rvalid, rdata);
  end

  typedef struct { int due; int id; logic [DW-1:0] data; } ret_t;
  ret_t          ret_q[$];
  int            cyc = 0, ptr_m = 0, owner_m = 0, n_checks = 0, n_pass = 0;
  bit            locked_m = 1'b0;
  logic [AW-1:0] last_addr_m = '0;
  logic [DW-1:0] last_data_m = '0;
  logic [N-1:0]  exp_gnt, exp_rvalid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_rdata;

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  // Applies one cycle of stimulus and computes what the arbiter should show in it.
  task automatic drive(input bit in_rst, input logic [N-1:0] r, input logic [N*AW-1:0] a,
                       input logic [N-1:0] lk);
    int g;
    g = -1;
    @(negedge clk);
    cyc++;
    rst_n = ~in_rst; req = r; addr = a; lock = lk;
    exp_gnt = '0; exp_rvalid = '0;
    if (in_rst) begin
      ret_q.delete(); ptr_m = 0; locked_m = 1'b0; last_addr_m = '0; last_data_m = '0;
    end else begin
      if (locked_m && bit_of(r, owner_m) && bit_of(lk, owner_m)) g = owner_m;
      else begin
        locked_m = 1'b0;
        for (int k = 0; k < N; k++)
          if (g < 0 && bit_of(r, (ptr_m + k) % N)) g = (ptr_m + k) % N;
        if (g >= 0) begin
          ptr_m = (g + 1) % N;
`ifdef ROM_ARB_LOCK_EN
          locked_m = bit_of(lk, g);
          owner_m  = g;
`endif
        end
      end
      if (g >= 0) begin
        exp_gnt     = N'(1) << g;
        last_addr_m = AW'(a >> (g * AW));
        ret_q.push_back('{cyc + LAT, g, rom_f(last_addr_m)});
      end
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        exp_rvalid  = N'(1) << ret_q[0].id;
        last_data_m = ret_q[0].data;
        void'(ret_q.pop_front());
      end
    end
    exp_addr  = last_addr_m;
    exp_rdata = last_data_m;
    #1;
  endtask

  function automatic logic [N*AW-1:0] addr_stride16();
    logic [N*AW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v = v | ((N*AW)'(i * 16) << (i * AW));
    return v;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, '1, addr_stride16(), '0);
      n_checks++; if (gnt !== '0) $display("FAIL reset.gnt cyc=%0d got=%b exp=0", cyc, gnt); else n_pass++;
      n_checks++; if (rvalid !== '0) $display("FAIL reset.rvalid cyc=%0d got=%b exp=0", cyc, rvalid); else n_pass++;
      n_checks++; if (rdata !== '0) $display("FAIL reset.rdata cyc=%0d got=%h exp=0", cyc, rdata); else n_pass++;
      n_checks++; if (rom_addr !== '0) $display("FAIL reset.rom_addr cyc=%0d got=%h exp=0", cyc, rom_addr); else n_pass++;
    end
    drive(1'b0, '1, addr_stride16(), '0);
    n_checks++; if (gnt !== 4'b0001) $display("FAIL reset.first_gnt cyc=%0d got=%b exp=0001", cyc, gnt); else n_pass++;
  endtask

  task automatic test_all_req();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, '1, addr_stride16(), '0);
      n_checks++; if (gnt !== exp_gnt) $display("FAIL all_req.gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); else n_pass++;
      n_checks++; if (rom_addr !== exp_addr) $display("FAIL all_req.rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, exp_addr); else n_pass++;
      n_checks++; if (rvalid !== exp_rvalid) $display("FAIL all_req.rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); else n_pass++;
      n_checks++; if (rdata !== exp_rdata) $display("FAIL all_req.rdata cyc=%0d got=%h exp=%h", cyc, rdata, exp_rdata); else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [N*AW-1:0] a;
    a = (N*AW)'(20'h12345) << (2 * AW);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b0100, a, '0);
      n_checks++; if (gnt !== 4'b0100) $display("FAIL single.gnt cyc=%0d got=%b exp=0100", cyc, gnt); else n_pass++;
      n_checks++; if (rom_addr !== 20'h12345) $display("FAIL single.rom_addr cyc=%0d got=%h exp=12345", cyc, rom_addr); else n_pass++;
      n_checks++; if (rvalid !== exp_rvalid) $display("FAIL single.rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); else n_pass++;
      n_checks++; if (rdata !== exp_rdata) $display("FAIL single.rdata cyc=%0d got=%h exp=%h", cyc, rdata, exp_rdata); else n_pass++;
    end
  endtask

  task automatic test_reset_inflight();
    logic [N*AW-1:0] a;
    a = (N*AW)'(20'h0ABCD) << AW;
    drive(1'b0, 4'b0010, a, '0);
    n_checks++; if (gnt !== 4'b0010) $display("FAIL inflight.gnt cyc=%0d got=%b exp=0010", cyc, gnt); else n_pass++;
    drive(1'b1, '0, a, '0);
    for (int i = 0; i < LAT + 4; i++) begin
      drive(1'b0, '0, a, '0);
      n_checks++; if (rvalid !== '0) $display("FAIL inflight.rvalid cyc=%0d got=%b exp=0", cyc, rvalid); else n_pass++;
      n_checks++; if (rdata !== exp_rdata) $display("FAIL inflight.rdata cyc=%0d got=%h exp=%h", cyc, rdata, exp_rdata); else n_pass++;
    end
  endtask

  task automatic test_alternate();
    logic [N*AW-1:0] a;
    a = {$urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0010, a, '0);
      n_checks++; if (gnt !== exp_gnt) $display("FAIL alternate.gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); else n_pass++;
      n_checks++; if (rvalid !== exp_rvalid) $display("FAIL alternate.rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); else n_pass++;
      n_checks++; if (rdata !== exp_rdata) $display("FAIL alternate.rdata cyc=%0d got=%h exp=%h", cyc, rdata, exp_rdata); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0]    cur_r, new_mask, lk;
    logic [N*AW-1:0] cur_a, field;
    cur_r = '0; cur_a = '0; lk = '0;
    for (int i = 0; i < 400; i++) begin
      // Requesters hold req/addr until granted, then pick a fresh request.
      new_mask = exp_gnt | ~cur_r;
      if (i == 0) new_mask = '1;
      cur_r = (cur_r & ~new_mask) | (N'($urandom()) & new_mask);
      for (int k = 0; k < N; k++) begin
        if (bit_of(new_mask, k)) begin
          field = (N*AW)'({AW{1'b1}}) << (k * AW);
          cur_a = (cur_a & ~field) | (((N*AW)'(AW'($urandom()))) << (k * AW));
        end
      end
      if ($urandom_range(0, 7) == 0) lk = N'($urandom());
      drive((i % 97) == 96, cur_r, cur_a, lk);
      n_checks++; if (gnt !== exp_gnt) $display("FAIL random.gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); else n_pass++;
      n_checks++; if (rom_addr !== exp_addr) $display("FAIL random.rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, exp_addr); else n_pass++;
      n_checks++; if (rvalid !== exp_rvalid) $display("FAIL random.rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); else n_pass++;
      n_checks++; if (rdata !== exp_rdata) $display("FAIL random.rdata cyc=%0d got=%h exp=%h", cyc, rdata, exp_rdata); else n_pass++;
    end
  endtask

`ifdef ROM_ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] want [8];
    want = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    drive(1'b1, '0, addr_stride16(), '0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '1, addr_stride16(), (i < 5) ? 4'b0001 : 4'b0000);
      n_checks++; if (gnt !== want[i]) $display("FAIL lock.gnt cyc=%0d got=%b exp=%b", cyc, gnt, want[i]); else n_pass++;
      n_checks++; if (gnt !== exp_gnt) $display("FAIL lock.model_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_req();
    test_single();
    test_reset_inflight();
    test_alternate();
`ifdef ROM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
